spi_dac_multi_master: RTL and testbench
=======================================

// Module: spi_dac_multi_master
// PURPOSE
//   Parametrised SPI master that drives one of several serial DACs over a shared sClk/MOSI bus.
//   Each DAC has its own active-low chip select.
//   Accepts a start/channel/data request from the control logic and shifts one frame out MSB-first.
//   Generates a timed active-low DAC reset after system reset.
//   Supersedes the fixed-width, single-DAC SPI driver, adding word width, divider, channel count and CPOL.
// PARAMETERS
//   DATA_W      16  bits per SPI frame (>=2)
//   CLK_DIV     4   system clocks per sClk half-period (>=1)
//   NUM_CH      4   number of DAC chip selects (>=1)
//   CH_ADDR_W   2   width of ch_sel (2**CH_ADDR_W >= NUM_CH)
//   CPOL        0   sClk idle level; CPHA fixed 0: MOSI changes on trailing edge, DAC samples on leading edge
//   RESET_HOLD  16  clocks resetDac stays low after reset deasserts (>=1)
// PORTS
//   clock     in   1          system clock, all logic on rising edge
//   reset     in   1          synchronous, active-high
//   start     in   1          request pulse/level, sampled only when busy=0
//   ch_sel    in   CH_ADDR_W  target DAC index, captured with start
//   data_in   in   DATA_W     frame payload, captured with start
//   busy      out  1          1 while in DAC_RST, SETUP, SHIFT or HOLD
//   done      out  1          1-cycle pulse when a frame completes
//   err       out  1          1-cycle pulse when start is rejected for ch_sel >= NUM_CH
//   sClk      out  1          SPI clock
//   MOSI      out  1          SPI data, MSB first
//   SPI_CS    out  NUM_CH     active-low chip selects, at most one low at a time
//   resetDac  out  1          active-low DAC reset
// BEHAVIOUR
//   Reset values (reset=1 sampled): state=DAC_RST, sClk=CPOL, MOSI=0, SPI_CS=all 1, resetDac=0, busy=1, done=0, err=0.
//   Reset has priority over everything; reset mid-frame aborts the frame on the next edge.
//     CS releases, no done pulse, and DAC_RST re-runs.
//   FSM states: DAC_RST -> IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
//   DAC_RST: resetDac=0 for RESET_HOLD clocks after reset drops; then resetDac=1, busy=0, go to IDLE.
//     start is ignored in this state.
//   IDLE, start=1, ch_sel<NUM_CH: latch data_in into shift reg and ch_sel; next cycle SPI_CS[ch]=0,
//     MOSI=data[DATA_W-1], busy=1, state SETUP.
//   IDLE, start=1, ch_sel>=NUM_CH: err=1 for one cycle, no bus activity, stay IDLE.
//   SETUP: hold CLK_DIV clocks with sClk=CPOL, then enter SHIFT.
//   SHIFT: divider counter 0..CLK_DIV-1; sClk toggles at each wrap; 2*DATA_W toggles total.
//     Trailing edge (return to CPOL) shifts next bit onto MOSI; no shift after the last trailing edge.
//   HOLD: CLK_DIV clocks with sClk=CPOL, CS still low; then SPI_CS=all 1, MOSI=0, done=1, busy=0, state IDLE.
//   CS-low window is exactly (2*DATA_W+2)*CLK_DIV clocks.
//   Earliest next start is accepted in the same cycle done=1, so back-to-back frames keep CS high >= 1 clock.
//   start while busy=1 is ignored, with no queueing; data_in/ch_sel changes while busy have no effect.
//   Divider counter and bit counter are sized from CLK_DIV and DATA_W ($clog2).
//     The bit counter wraps only through the HOLD exit, never mid-frame.
// TESTING  (DATA_W=16, CLK_DIV=2, NUM_CH=4, CH_ADDR_W=2, RESET_HOLD=8, CPOL=0 unless noted)
//   Reset 3 clocks -> resetDac=0 during reset + 8 clocks after; busy=1 then 0; SPI_CS=4'b1111; sClk=0.
//   Start ch 2, data 16'hA5C3 -> SPI_CS=4'b1011 for 68 clocks; 16 rising sClk edges;
//     MOSI at rising edges = A5C3 MSB first; single done pulse as CS goes 1111.
//   Start ch 0 data 16'h1234, then start ch 1 data 16'hFFFF at bit 5 -> second request ignored;
//     only 1234 on ch 0; one done pulse.
//   ch_sel=3 is valid: frame runs on SPI_CS[3]. Build NUM_CH=3, ch_sel=3 -> err pulse, CS stays 1, busy 0.
//   reset asserted after 7th rising sClk -> next edge SPI_CS=1111, sClk=0, resetDac=0, no done;
//     a later start of 16'h0001 completes correctly.
//   CPOL=1 build, data 16'h8001 -> sClk idles 1; DAC samples on falling edges: 1,0 x14,1.

Source files
------------

// File: rtl/spi_dac_multi_master.sv
// spi_dac_multi_master
// SPI master for a bank of serial DACs sharing sClk/MOSI, each with its own
// active-low chip select. Shifts one DATA_W-bit frame MSB first (CPHA=0)
// and produces a timed active-low DAC reset after system reset.
module spi_dac_multi_master #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int NUM_CH     = 4,
  parameter int CH_ADDR_W  = 2,
  parameter int CPOL       = 0,
  parameter int RESET_HOLD = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CH_ADDR_W-1:0] ch_sel,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 sClk,
  output logic                 MOSI,
  output logic [NUM_CH-1:0]    SPI_CS,
  output logic                 resetDac
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int RST_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RESET_HOLD - 1);
  localparam logic [CH_ADDR_W:0] NUM_CH_EXT = (CH_ADDR_W + 1)'(NUM_CH);
  localparam logic [NUM_CH-1:0]  CS_ONE     = NUM_CH'(1);
  localparam logic               SCLK_IDLE  = (CPOL != 0);

  typedef enum logic [2:0] {
    DAC_RST,
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t state;
  state_t state_next;

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [RST_W-1:0]  rst_cnt;
  logic [DATA_W-1:0] shift_reg;

  logic div_wrap;
  logic rst_wrap;
  logic ch_ok;
  logic accept;
  logic reject;
  logic trailing;
  logic last_edge;

  // MOSI always shows the MSB of the shift register, which is cleared when idle
  assign MOSI     = shift_reg[DATA_W-1];
  assign busy     = (state != IDLE);
  assign resetDac = (state != DAC_RST);

  // State register; reset always restarts the DAC reset sequence
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DAC_RST;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the request/edge qualifiers used by the datapath
  always_comb begin
    state_next = state;
    div_wrap   = (div_cnt == DIV_LAST);
    rst_wrap   = (rst_cnt == RST_LAST);
    ch_ok      = ({1'b0, ch_sel} < NUM_CH_EXT);
    accept     = 1'b0;
    reject     = 1'b0;
    trailing   = (sClk != SCLK_IDLE);
    last_edge  = trailing && (bit_cnt == BIT_LAST);
    case (state)
      DAC_RST: begin
        if (rst_wrap) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (start) begin
          if (ch_ok) begin
            accept     = 1'b1;
            state_next = SETUP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SETUP: begin
        if (div_wrap) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (div_wrap && last_edge) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (div_wrap) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = DAC_RST;
      end
    endcase
  end

  // Counters, shift register, SPI clock, chip selects and status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rst_cnt   <= '0;
      shift_reg <= '0;
      sClk      <= SCLK_IDLE;
      SPI_CS    <= '1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        DAC_RST: begin
          rst_cnt <= rst_wrap ? '0 : rst_cnt + 1'b1;
        end
        IDLE: begin
          if (accept) begin
            shift_reg <= data_in;
            SPI_CS    <= ~(CS_ONE << ch_sel);
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end
          if (reject) begin
            err <= 1'b1;
          end
        end
        SETUP: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        end
        SHIFT: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
          if (div_wrap) begin
            sClk <= ~sClk;
            if (trailing && !last_edge) begin
              shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
          if (div_wrap) begin
            SPI_CS    <= '1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            done      <= 1'b1;
          end
        end
        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dac_multi_master.sv
// tb_spi_dac_multi_master
// Directed bench for the multi-DAC SPI master: a main build plus a
// three-channel build and a CPOL=1 build sharing the clock.
module tb_spi_dac_multi_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  ch_sel;
  logic [15:0] data_in;
  logic        busy, done, err, sClk, MOSI, resetDac;
  logic [3:0]  SPI_CS;

  logic        reset_aux;
  logic        n3_start;
  logic [1:0]  n3_ch_sel;
  logic [15:0] n3_data_in;
  logic        n3_busy, n3_done, n3_err, n3_sClk, n3_MOSI, n3_resetDac;
  logic [2:0]  n3_SPI_CS;

  logic        p_start;
  logic [1:0]  p_ch_sel;
  logic [15:0] p_data_in;
  logic        p_busy, p_done, p_err, p_sClk, p_MOSI, p_resetDac;
  logic [3:0]  p_SPI_CS;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  spi_dac_multi_master #(
    .DATA_W(16), .CLK_DIV(2), .NUM_CH(4), .CH_ADDR_W(2), .CPOL(0), .RESET_HOLD(8)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .ch_sel(ch_sel), .data_in(data_in),
    .busy(busy), .done(done), .err(err), .sClk(sClk), .MOSI(MOSI),
    .SPI_CS(SPI_CS), .resetDac(resetDac)
  );

  spi_dac_multi_master #(
    .DATA_W(16), .CLK_DIV(2), .NUM_CH(3), .CH_ADDR_W(2), .CPOL(0), .RESET_HOLD(8)
  ) u_n3 (
    .clock(clock), .reset(reset_aux), .start(n3_start), .ch_sel(n3_ch_sel),
    .data_in(n3_data_in), .busy(n3_busy), .done(n3_done), .err(n3_err),
    .sClk(n3_sClk), .MOSI(n3_MOSI), .SPI_CS(n3_SPI_CS), .resetDac(n3_resetDac)
  );

  spi_dac_multi_master #(
    .DATA_W(16), .CLK_DIV(2), .NUM_CH(4), .CH_ADDR_W(2), .CPOL(1), .RESET_HOLD(8)
  ) u_pol (
    .clock(clock), .reset(reset_aux), .start(p_start), .ch_sel(p_ch_sel),
    .data_in(p_data_in), .busy(p_busy), .done(p_done), .err(p_err),
    .sClk(p_sClk), .MOSI(p_MOSI), .SPI_CS(p_SPI_CS), .resetDac(p_resetDac)
  );

  // Issue a one-cycle request to the main build; returns on the first cycle of the frame
  task automatic launch(input logic [1:0] ch, input logic [15:0] data);
    start   = 1'b1;
    ch_sel  = ch;
    data_in = data;
    @(negedge clock);
    start   = 1'b0;
  endtask

  // Observe the main build for n cycles, optionally issuing one extra request at cycle inj
  task automatic capture_frame(input int n, input int inj, input logic [1:0] inj_ch,
                               input logic [15:0] inj_data, input logic [3:0] cs_exp,
                               output int cs_low, output int cs_match, output int rises,
                               output logic [31:0] bits, output int dones,
                               output int busy_cnt, output int done_bad);
    logic       prev_sclk;
    logic [3:0] prev_cs;
    prev_sclk = 1'b0;
    prev_cs   = SPI_CS;
    cs_low = 0; cs_match = 0; rises = 0; bits = '0; dones = 0; busy_cnt = 0; done_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (SPI_CS != 4'hF) cs_low++;
      if (SPI_CS == cs_exp) cs_match++;
      if (busy) busy_cnt++;
      if (sClk && !prev_sclk) begin
        rises++;
        bits = {bits[30:0], MOSI};
      end
      if (done) begin
        dones++;
        if (SPI_CS != 4'hF || prev_cs == 4'hF) done_bad++;
      end
      prev_sclk = sClk;
      prev_cs   = SPI_CS;
      if (i == inj) begin
        start   = 1'b1;
        ch_sel  = inj_ch;
        data_in = inj_data;
      end else if (i == inj + 1) begin
        start = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; reset_aux = 1'b1;
    start = 1'b0; ch_sel = '0; data_in = '0;
    n3_start = 1'b0; n3_ch_sel = '0; n3_data_in = '0;
    p_start = 1'b0; p_ch_sel = '0; p_data_in = '0;
    repeat (3) @(negedge clock);
    tests++;
    if ({resetDac, busy, SPI_CS, sClk, MOSI, done, err} !== {1'b0, 1'b1, 4'hF, 4'b0000}) begin
      fails++;
      $display("[TB] FAIL reset_values: got rd=%b busy=%b cs=%b sclk=%b mosi=%b done=%b err=%b expected 0 1 1111 0 0 0 0",
               resetDac, busy, SPI_CS, sClk, MOSI, done, err);
    end
    reset = 1'b0; reset_aux = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (resetDac !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("[TB] FAIL reset_hold_%0d: got rd=%b busy=%b expected 0 1", i, resetDac, busy);
      end
      @(negedge clock);
    end
    tests++;
    if (resetDac !== 1'b1 || busy !== 1'b0 || SPI_CS !== 4'hF) begin
      fails++;
      $display("[TB] FAIL reset_release: got rd=%b busy=%b cs=%b expected 1 0 1111", resetDac, busy, SPI_CS);
    end
  endtask

  task automatic test_single_frame;
    int cs_low, cs_match, rises, dones, busy_cnt, done_bad;
    logic [31:0] bits;
    launch(2'd2, 16'hA5C3);
    capture_frame(80, -10, 2'd0, 16'h0, 4'b1011, cs_low, cs_match, rises, bits, dones, busy_cnt, done_bad);
    tests++;
    if (cs_low !== 68 || cs_match !== 68) begin
      fails++;
      $display("[TB] FAIL frame_cs_window: got low=%0d on_ch2=%0d expected 68 68", cs_low, cs_match);
    end
    tests++;
    if (rises !== 16 || bits !== 32'h0000A5C3) begin
      fails++;
      $display("[TB] FAIL frame_mosi: got rises=%0d bits=%h expected 16 0000a5c3", rises, bits);
    end
    tests++;
    if (dones !== 1 || done_bad !== 0 || busy_cnt !== 68) begin
      fails++;
      $display("[TB] FAIL frame_done: got dones=%0d bad=%0d busy=%0d expected 1 0 68", dones, done_bad, busy_cnt);
    end
    tests++;
    if (sClk !== 1'b0 || MOSI !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame_idle_bus: got sclk=%b mosi=%b expected 0 0", sClk, MOSI);
    end
  endtask

  task automatic test_ignore_busy;
    int cs_low, cs_match, rises, dones, busy_cnt, done_bad;
    logic [31:0] bits;
    launch(2'd0, 16'h1234);
    capture_frame(80, 24, 2'd1, 16'hFFFF, 4'b1110, cs_low, cs_match, rises, bits, dones, busy_cnt, done_bad);
    tests++;
    if (cs_low !== 68 || cs_match !== 68 || bits !== 32'h00001234 || dones !== 1) begin
      fails++;
      $display("[TB] FAIL ignore_busy: got low=%0d on_ch0=%0d bits=%h dones=%0d expected 68 68 00001234 1",
               cs_low, cs_match, bits, dones);
    end
    tests++;
    if (busy !== 1'b0 || SPI_CS !== 4'hF) begin
      fails++;
      $display("[TB] FAIL ignore_no_queue: got busy=%b cs=%b expected 0 1111", busy, SPI_CS);
    end
  endtask

  task automatic test_ch3_valid;
    int cs_low, cs_match, rises, dones, busy_cnt, done_bad;
    logic [31:0] bits;
    launch(2'd3, 16'h0F0F);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ch3_no_err: got err=%b expected 0", err);
    end
    capture_frame(80, -10, 2'd0, 16'h0, 4'b0111, cs_low, cs_match, rises, bits, dones, busy_cnt, done_bad);
    tests++;
    if (cs_match !== 68 || bits !== 32'h00000F0F || dones !== 1) begin
      fails++;
      $display("[TB] FAIL ch3_frame: got on_ch3=%0d bits=%h dones=%0d expected 68 00000f0f 1",
               cs_match, bits, dones);
    end
  endtask

  task automatic test_back_to_back;
    int cs_low, cs_match, rises, dones, busy_cnt, done_bad;
    logic [31:0] bits;
    launch(2'd1, 16'h3C5A);
    capture_frame(150, 68, 2'd2, 16'hC001, 4'b1101, cs_low, cs_match, rises, bits, dones, busy_cnt, done_bad);
    tests++;
    if (cs_low !== 136 || cs_match !== 68 || busy_cnt !== 136) begin
      fails++;
      $display("[TB] FAIL b2b_cs: got low=%0d on_ch1=%0d busy=%0d expected 136 68 136", cs_low, cs_match, busy_cnt);
    end
    tests++;
    if (rises !== 32 || bits !== 32'h3C5AC001 || dones !== 2 || done_bad !== 0) begin
      fails++;
      $display("[TB] FAIL b2b_data: got rises=%0d bits=%h dones=%0d bad=%0d expected 32 3c5ac001 2 0",
               rises, bits, dones, done_bad);
    end
  endtask

  task automatic test_invalid_channel;
    n3_start = 1'b1; n3_ch_sel = 2'd3; n3_data_in = 16'hBEEF;
    @(negedge clock);
    n3_start = 1'b0;
    tests++;
    if (n3_err !== 1'b1 || n3_SPI_CS !== 3'b111 || n3_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL err_pulse: got err=%b cs=%b busy=%b expected 1 111 0", n3_err, n3_SPI_CS, n3_busy);
    end
    @(negedge clock);
    tests++;
    if (n3_err !== 1'b0 || n3_SPI_CS !== 3'b111 || n3_busy !== 1'b0 ||
        {n3_done, n3_sClk, n3_MOSI, n3_resetDac} !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL err_one_cycle: got err=%b cs=%b busy=%b done=%b sclk=%b mosi=%b rd=%b expected 0 111 0 0 0 0 1",
               n3_err, n3_SPI_CS, n3_busy, n3_done, n3_sClk, n3_MOSI, n3_resetDac);
    end
    n3_start = 1'b1; n3_ch_sel = 2'd2; n3_data_in = 16'h0003;
    @(negedge clock);
    n3_start = 1'b0;
    tests++;
    if (n3_err !== 1'b0 || n3_SPI_CS !== 3'b011 || n3_busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL top_channel_ok: got err=%b cs=%b busy=%b expected 0 011 1", n3_err, n3_SPI_CS, n3_busy);
    end
    repeat (70) @(negedge clock);
  endtask

  task automatic test_cpol1;
    int falls, cs_low, dones;
    logic prev;
    logic [15:0] bits;
    tests++;
    if (p_sClk !== 1'b1 || p_busy !== 1'b0 || p_resetDac !== 1'b1 || {p_err, p_MOSI} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL cpol1_idle: got sclk=%b busy=%b rd=%b err=%b mosi=%b expected 1 0 1 0 0",
               p_sClk, p_busy, p_resetDac, p_err, p_MOSI);
    end
    p_start = 1'b1; p_ch_sel = 2'd0; p_data_in = 16'h8001;
    @(negedge clock);
    p_start = 1'b0;
    prev = 1'b1; falls = 0; cs_low = 0; dones = 0; bits = '0;
    for (int i = 0; i < 80; i++) begin
      if (p_SPI_CS != 4'hF) cs_low++;
      if (p_done) dones++;
      if (!p_sClk && prev) begin
        falls++;
        bits = {bits[14:0], p_MOSI};
      end
      prev = p_sClk;
      @(negedge clock);
    end
    tests++;
    if (falls !== 16 || bits !== 16'h8001) begin
      fails++;
      $display("[TB] FAIL cpol1_samples: got falls=%0d bits=%h expected 16 8001", falls, bits);
    end
    tests++;
    if (cs_low !== 68 || dones !== 1 || p_sClk !== 1'b1) begin
      fails++;
      $display("[TB] FAIL cpol1_frame: got low=%0d dones=%0d sclk=%b expected 68 1 1", cs_low, dones, p_sClk);
    end
  endtask

  task automatic test_reset_mid_frame;
    int rises, done_seen, cs_low, cs_match, r2, dones, busy_cnt, done_bad;
    logic prev;
    logic idle_seen;
    logic [31:0] bits;
    launch(2'd0, 16'hF0F0);
    prev = 1'b0; rises = 0;
    for (int i = 0; i < 40; i++) begin
      if (sClk && !prev) rises++;
      prev = sClk;
      if (rises == 7) break;
      @(negedge clock);
    end
    tests++;
    if (rises !== 7) begin
      fails++;
      $display("[TB] FAIL abort_reach_bit7: got rises=%0d expected 7", rises);
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (SPI_CS !== 4'hF || sClk !== 1'b0 || resetDac !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_state: got cs=%b sclk=%b rd=%b done=%b busy=%b expected 1111 0 0 0 1",
               SPI_CS, sClk, resetDac, done, busy);
    end
    reset = 1'b0;
    done_seen = 0; idle_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_seen++;
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    tests++;
    if (idle_seen !== 1'b1 || done_seen !== 0) begin
      fails++;
      $display("[TB] FAIL abort_recover: got idle=%b dones=%0d expected 1 0", idle_seen, done_seen);
    end
    launch(2'd0, 16'h0001);
    capture_frame(80, -10, 2'd0, 16'h0, 4'b1110, cs_low, cs_match, r2, bits, dones, busy_cnt, done_bad);
    tests++;
    if (cs_match !== 68 || r2 !== 16 || bits !== 32'h00000001 || dones !== 1) begin
      fails++;
      $display("[TB] FAIL abort_next_frame: got on_ch0=%0d rises=%0d bits=%h dones=%0d expected 68 16 00000001 1",
               cs_match, r2, bits, dones);
    end
  endtask

  // Run every scenario in order and report the totals
  initial begin
    @(negedge clock);
    test_reset();
    test_single_frame();
    test_ignore_busy();
    test_ch3_valid();
    test_back_to_back();
    test_invalid_channel();
    test_cpol1();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
